// File: rtl/ptt_band_cond.sv
// Conditions the raw PTT and band lines for the band sequencer: synchronise,
// debounce, hold band steady while keyed, and force a lockout on transmit time-out.
module ptt_band_cond #(
  parameter int DB_CYCLES   = 50000,
  parameter int TICK_CYCLES = 50000,
  parameter int TOT_TICKS   = 180000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ptt_in,
  input  logic [2:0] band_in,
  input  logic       tot_clear,
  output logic       ptt,
  output logic [2:0] band,
  output logic       tot_fault
);

  localparam int DW = $clog2(DB_CYCLES);
  localparam int PW = (TICK_CYCLES < 2) ? 1 : $clog2(TICK_CYCLES);
  localparam int TW = (TOT_TICKS < 2) ? 1 : $clog2(TOT_TICKS);

  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] TICK_LAST = PW'((TICK_CYCLES < 1) ? 0 : TICK_CYCLES - 1);
  localparam logic [TW-1:0] TOT_LAST  = TW'((TOT_TICKS < 1) ? 0 : TOT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_RX,
    ST_TX,
    ST_LOCK
  } state_t;

  logic          r_ptt_s1, r_ptt_s2;
  logic [2:0]    r_band_s1, r_band_s2;
  logic          r_ptt_db;
  logic [DW-1:0] r_ptt_cnt;
  logic [2:0]    r_band_db;
  logic [DW-1:0] r_band_cnt;
  state_t        r_state;
  state_t        w_state_next;
  logic          w_timeout;
  logic          w_fault_set;
  logic          r_ptt;
  logic [2:0]    r_band;
  logic          r_fault;
  logic [PW-1:0] r_pre;
  logic [TW-1:0] r_ticks;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptt_s1  <= 1'b1;
      r_ptt_s2  <= 1'b1;
      r_band_s1 <= 3'b000;
      r_band_s2 <= 3'b000;
    end else begin
      r_ptt_s1  <= ptt_in;
      r_ptt_s2  <= r_ptt_s1;
      r_band_s1 <= band_in;
      r_band_s2 <= r_band_s1;
    end
  end

  // Acceptance is checked before the restart conditions so a value that has
  // differed for the full window is taken even if the line moves again now.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptt_db  <= 1'b1;
      r_ptt_cnt <= '0;
    end else if (r_ptt_s2 != r_ptt_db && r_ptt_cnt == DB_LAST) begin
      r_ptt_db  <= r_ptt_s2;
      r_ptt_cnt <= '0;
    end else if (r_ptt_s2 == r_ptt_db || r_ptt_s1 != r_ptt_s2) begin
      r_ptt_cnt <= '0;
    end else begin
      r_ptt_cnt <= r_ptt_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_band_db  <= 3'b000;
      r_band_cnt <= '0;
    end else if (r_band_s2 != r_band_db && r_band_cnt == DB_LAST) begin
      r_band_db  <= r_band_s2;
      r_band_cnt <= '0;
    end else if (r_band_s2 == r_band_db || r_band_s1 != r_band_s2) begin
      r_band_cnt <= '0;
    end else begin
      r_band_cnt <= r_band_cnt + DW'(1);
    end
  end

  // Fires on the edge where the tick count would reach TOT_TICKS.
  assign w_timeout = (TOT_TICKS != 0) && (r_pre == TICK_LAST) && (r_ticks == TOT_LAST);

  always_comb begin
    w_state_next = r_state;
    w_fault_set  = 1'b0;
    case (r_state)
      ST_RX: begin
        if (!r_ptt_db && r_band == r_band_db) w_state_next = ST_TX;
      end
      ST_TX: begin
        if (r_ptt_db) begin
          w_state_next = ST_RX;
        end else if (w_timeout) begin
          w_state_next = ST_LOCK;
          w_fault_set  = 1'b1;
        end
      end
      ST_LOCK: begin
        if (r_ptt_db) w_state_next = ST_RX;
      end
      default: w_state_next = ST_RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RX;
      r_ptt   <= 1'b1;
      r_band  <= 3'b000;
      r_fault <= 1'b0;
      r_pre   <= '0;
      r_ticks <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptt   <= (w_state_next != ST_TX);
      if (r_state == ST_RX) r_band <= r_band_db;
      if (w_fault_set) r_fault <= 1'b1;
      else if (tot_clear) r_fault <= 1'b0;
      // Timer is held at zero outside TX, so every TX entry starts from zero.
      if (r_state != ST_TX) begin
        r_pre   <= '0;
        r_ticks <= '0;
      end else if (r_pre == TICK_LAST) begin
        r_pre <= '0;
        if (r_ticks != '1) r_ticks <= r_ticks + TW'(1);
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end
  end

  assign ptt       = r_ptt;
  assign band      = r_band;
  assign tot_fault = r_fault;

endmodule

// File: tb/tb_ptt_band_cond.sv
// Bench for ptt_band_cond: directed scenarios followed by randomized input
// activity, every cycle compared against a behavioural model of the conditioner.
module tb_ptt_band_cond;

  localparam int DB   = 4;
  localparam int TICK = 10;
  localparam int TOT  = 5;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       ptt_in    = 1'b1;
  logic [2:0] band_in   = 3'b000;
  logic       tot_clear = 1'b0;
  logic       ptt;
  logic [2:0] band;
  logic       tot_fault;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Behavioural model: raw-sample history, accepted values, and a keyed/locked view.
  bit         m_hist_p[0:DB];
  logic [2:0] m_hist_b[0:DB];
  bit         m_db_p;
  logic [2:0] m_db_b;
  bit         m_keyed;
  bit         m_locked;
  bit         m_fault;
  logic [2:0] m_band;
  int         m_age;

  ptt_band_cond #(
    .DB_CYCLES  (DB),
    .TICK_CYCLES(TICK),
    .TOT_TICKS  (TOT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ptt_in   (ptt_in),
    .band_in  (band_in),
    .tot_clear(tot_clear),
    .ptt      (ptt),
    .band     (band),
    .tot_fault(tot_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // A value is accepted once the synchronised line (raw delayed two cycles) has
  // shown the same new value for DB consecutive cycles.
  task automatic model_edge();
    bit         p_all, b_all, fault_set;
    bit         nd_p;
    logic [2:0] nd_b;
    if (reset) begin
      for (int i = 0; i <= DB; i++) begin
        m_hist_p[i] = 1'b1;
        m_hist_b[i] = 3'b000;
      end
      m_db_p   = 1'b1;
      m_db_b   = 3'b000;
      m_keyed  = 1'b0;
      m_locked = 1'b0;
      m_fault  = 1'b0;
      m_band   = 3'b000;
      m_age    = 0;
    end else begin
      p_all = 1'b1;
      b_all = 1'b1;
      for (int i = 2; i <= DB; i++) begin
        if (m_hist_p[i] != m_hist_p[1]) p_all = 1'b0;
        if (m_hist_b[i] != m_hist_b[1]) b_all = 1'b0;
      end
      nd_p = (p_all && m_hist_p[1] != m_db_p) ? m_hist_p[1] : m_db_p;
      nd_b = (b_all && m_hist_b[1] != m_db_b) ? m_hist_b[1] : m_db_b;
      fault_set = 1'b0;
      if (!m_keyed && !m_locked) begin
        if (!m_db_p && m_band == m_db_b) begin
          m_keyed = 1'b1;
          m_age   = 0;
        end
        m_band = m_db_b;
      end else if (m_keyed) begin
        if (m_db_p) begin
          m_keyed = 1'b0;
        end else if (TOT != 0 && m_age + 1 == TOT * TICK) begin
          m_keyed   = 1'b0;
          m_locked  = 1'b1;
          fault_set = 1'b1;
        end else begin
          m_age++;
        end
      end else if (m_db_p) begin
        m_locked = 1'b0;
      end
      if (fault_set) m_fault = 1'b1;
      else if (tot_clear) m_fault = 1'b0;
      m_db_p = nd_p;
      m_db_b = nd_b;
      for (int i = DB; i >= 1; i--) begin
        m_hist_p[i] = m_hist_p[i-1];
        m_hist_b[i] = m_hist_b[i-1];
      end
      m_hist_p[0] = ptt_in;
      m_hist_b[0] = band_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("model_ptt", 32'(ptt), 32'(!m_keyed));
    check("model_band", 32'(band), 32'(m_band));
    check("model_fault", 32'(tot_fault), 32'(m_fault));
  endtask

  initial begin
    int p_hold;
    int b_hold;
    int txn;

    tick();
    tick();
    reset = 1'b0;
    $display("txn reset: ptt=%0b band=%03b tot_fault=%0b", ptt, band, tot_fault);
    check("rst_ptt", 32'(ptt), 1);
    check("rst_band", 32'(band), 0);
    check("rst_fault", 32'(tot_fault), 0);

    band_in = 3'b110;
    repeat (6) tick();
    check("band_6", 32'(band), 0);
    tick();
    check("band_7", 32'(band), 6);
    check("band_ptt", 32'(ptt), 1);
    $display("txn band select: band=%03b", band);

    ptt_in = 1'b0;
    repeat (3) tick();
    ptt_in = 1'b1;
    repeat (10) tick();
    check("glitch_ptt", 32'(ptt), 1);
    $display("txn ptt glitch: ptt=%0b", ptt);

    ptt_in = 1'b0;
    repeat (6) tick();
    check("key_6", 32'(ptt), 1);
    tick();
    check("key_7", 32'(ptt), 0);
    band_in = 3'b000;
    repeat (20) tick();
    check("tx_band_frozen", 32'(band), 6);
    ptt_in = 1'b1;
    repeat (6) tick();
    check("unkey_6", 32'(ptt), 0);
    tick();
    check("unkey_7", 32'(ptt), 1);
    check("unkey_band", 32'(band), 6);
    tick();
    check("band_after", 32'(band), 0);
    $display("txn key/release: ptt=%0b band=%03b", ptt, band);

    repeat (5) tick();
    ptt_in = 1'b0;
    repeat (7) tick();
    check("tot_key", 32'(ptt), 0);
    repeat (49) tick();
    check("tot_49_ptt", 32'(ptt), 0);
    check("tot_49_fault", 32'(tot_fault), 0);
    tick();
    check("tot_50_ptt", 32'(ptt), 1);
    check("tot_50_fault", 32'(tot_fault), 1);
    repeat (43) tick();
    check("lock_hold", 32'(ptt), 1);
    $display("txn time-out: ptt=%0b tot_fault=%0b", ptt, tot_fault);
    ptt_in = 1'b1;
    repeat (10) tick();
    check("lock_released", 32'(ptt), 1);
    ptt_in = 1'b0;
    repeat (7) tick();
    check("rekey", 32'(ptt), 0);
    check("fault_sticky", 32'(tot_fault), 1);
    tot_clear = 1'b1;
    tick();
    tot_clear = 1'b0;
    check("tot_clear", 32'(tot_fault), 0);
    check("clear_keeps_tx", 32'(ptt), 0);
    $display("txn re-key/clear: ptt=%0b tot_fault=%0b", ptt, tot_fault);
    ptt_in = 1'b1;
    repeat (10) tick();

    band_in = 3'b011;
    ptt_in  = 1'b0;
    repeat (6) tick();
    check("sim_band_6", 32'(band), 0);
    tick();
    check("sim_band_7", 32'(band), 3);
    check("sim_ptt_7", 32'(ptt), 1);
    tick();
    check("sim_ptt_8", 32'(ptt), 0);
    $display("txn simultaneous settle: ptt=%0b band=%03b", ptt, band);

    band_in = 3'b000;
    repeat (10) tick();
    check("midtx_ptt", 32'(ptt), 0);
    check("midtx_band", 32'(band), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_tx_ptt", 32'(ptt), 1);
    check("rst_tx_band", 32'(band), 0);
    check("rst_tx_fault", 32'(tot_fault), 0);
    repeat (6) tick();
    check("rst_rekey_6", 32'(ptt), 1);
    tick();
    check("rst_rekey_7", 32'(ptt), 0);
    $display("txn reset mid-TX: ptt=%0b band=%03b", ptt, band);

    p_hold = $urandom_range(1, 80);
    b_hold = $urandom_range(1, 30);
    txn    = 0;
    repeat (3000) begin
      p_hold = p_hold - 1;
      if (p_hold == 0) begin
        ptt_in = ~ptt_in;
        p_hold = ptt_in ? $urandom_range(1, 40) : $urandom_range(1, 80);
        txn++;
        $display("txn %0d: ptt_in=%0b band_in=%03b hold=%0d", txn, ptt_in, band_in, p_hold);
      end
      b_hold = b_hold - 1;
      if (b_hold == 0) begin
        band_in = 3'($urandom_range(0, 7));
        b_hold  = $urandom_range(1, 30);
      end
      tot_clear = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 699) == 0);
      tick();
    end
    reset     = 1'b0;
    tot_clear = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ptt_band_cond.md
# ptt_band_cond

Input conditioner that produces the `ptt` and `band` signals consumed by the band sequencer (`mux144`).

- **Inputs:** the raw, asynchronous PTT line and the band-data lines from the transceiver connector.
- **Processing:** synchronise, debounce, freeze band while transmitting, enforce a transmit time-out.
- **Outputs:** a clean active-low `ptt` and a stable 3-bit `band`, in exactly the format the sequencer expects.
- **Placement:** sits between the connector pins and the sequencer.

## Interface
Parameters:
- `DB_CYCLES`, 50000 — clock cycles an input must differ continuously from its debounced value before being accepted (≥2).
- `TICK_CYCLES`, 50000 — prescaler period for the time-out tick (1 ms at 50 MHz).
- `TOT_TICKS`, 180000 — ticks of continuous TX before forced lockout; 0 disables time-out.

Ports:
- `clk` in 1 — single clock; every register is on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `ptt_in` in 1 — raw PTT, active low, asynchronous.
- `band_in` in 3 — raw band code, asynchronous.
- `tot_clear` in 1 — one-cycle pulse that clears `tot_fault`.
- `ptt` out 1 — conditioned PTT to the sequencer, active low. Reset value 1.
- `band` out 3 — conditioned band to the sequencer. Reset value 3'b000.
- `tot_fault` out 1 — sticky time-out flag. Reset value 0.

## Operation
**Synchronisers**
- Two-flop synchroniser on `ptt_in` and on each `band_in` bit.
- Reset values: 1 for the PTT path, 000 for the band path.

**Debounce**
- Separate logic for PTT and for the band vector; one counter per path.
- The counter clears whenever the synced value equals the debounced value, or whenever the synced value changes.
- Otherwise the counter increments. When it reaches `DB_CYCLES-1` with the input still differing, the debounced value takes the synced value.
- Band bits are debounced as one vector: any bit change restarts the count.
- Glitches shorter than `DB_CYCLES` cycles are never passed through.

**FSM states:** RX, TX, LOCKOUT. Reset state is RX.
- **RX**
  - `ptt`=1.
  - `band` register loads the debounced band every cycle.
  - Go to TX when debounced PTT = 0 and `band` already equals the debounced band.
  - If band and PTT settle in the same cycle, `band` updates first and TX follows one cycle later. `ptt` never falls in a cycle where `band` changes.
- **TX**
  - `ptt`=0.
  - `band` is frozen; band changes are held and applied only after return to RX.
  - Go to RX when debounced PTT = 1.
  - If `TOT_TICKS`≠0 and the tick count reaches `TOT_TICKS`, go to LOCKOUT and set `tot_fault`. A PTT release in that same cycle takes priority: go to RX, no fault.
- **LOCKOUT**
  - `ptt`=1.
  - `band` is frozen.
  - Go to RX only when debounced PTT = 1. Held PTT never re-keys.

**Time-out counter**
- The prescaler and tick counter both clear on entry to TX.
- The tick counter counts prescaler wraps while in TX.

**`tot_fault`**
- Sticky: set on the TX→LOCKOUT transition, cleared by `tot_clear`.
- If set and clear occur in the same cycle, set wins.
- `tot_clear` has no effect on FSM state.

**Reset**
- Reset at any time, including mid-TX or in LOCKOUT, returns all registers to reset values.
- On the cycle after the reset edge: `ptt`=1, `band`=000, `tot_fault`=0.

**Widths:** counters sized with `$clog2` of their parameter. No wrap: each counter stops at its terminal value.

## Timing
- Raw `ptt_in` edge (held stable) → `ptt` output edge: 2 + `DB_CYCLES` + 1 cycles, when band is already settled.
- Raw `band_in` change (held stable) in RX → `band` output: 2 + `DB_CYCLES` + 1 cycles.
- TX→RX:
  - `ptt` rises 2 + `DB_CYCLES` + 1 cycles after the raw release.
  - A band held during TX appears on `band` one cycle after `ptt` rises.
- Time-out: `ptt` rises and `tot_fault` sets exactly `TOT_TICKS`·`TICK_CYCLES` cycles after `ptt` fell.
- `tot_clear`: `tot_fault`=0 on the next cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: `DB_CYCLES`=4, `TICK_CYCLES`=10, `TOT_TICKS`=5; inputs driven from reset with `ptt_in`=1, `band_in`=000.
- **Reset values:** assert `reset` for 2 cycles → `ptt`=1, `band`=000, `tot_fault`=0.
- **Band and glitch rejection:** `band_in`=110 held → `band`=110 exactly 7 cycles later, `ptt` stays 1. Then a 3-cycle low pulse on `ptt_in` → `ptt` stays 1.
- **Key and release:**
  - `ptt_in`=0 held → `ptt`=0 after 7 cycles.
  - `band_in`=000 during TX → `band` stays 110.
  - `ptt_in`=1 → `ptt`=1 after 7 cycles; `band`=000 one cycle later.
- **Time-out and lockout:**
  - `ptt_in`=0 held 100 cycles → `ptt`=1 and `tot_fault`=1 exactly 50 cycles after `ptt` fell; `ptt` stays 1 while `ptt_in` stays low.
  - Release, then re-key → `ptt`=0 again.
  - Pulse `tot_clear` → `tot_fault`=0 next cycle.
- **Simultaneous settle:** `band_in` and `ptt_in` change in the same cycle → `band` updates one cycle before `ptt` falls.
- **Reset mid-TX:** assert `reset` while `ptt`=0 with `ptt_in` still low → `ptt`=1, `band`=000 on the next cycle. After reset, `ptt`=0 again 7 cycles later.
